// File: rtl/pulse_seq_pkg.sv
// Shared types and default widths for the pulse sequencer.
// Holds the FSM state encoding and the default counter widths.
package pulse_seq_pkg;

   localparam int CNT_W   = 30;
   localparam int BURST_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_sequencer_if.sv
// Config handshake, control strobes and pulse outputs of the sequencer.
// Master drives config/control; slave is the sequencer.
interface pulse_sequencer_if #(
   parameter int CNT_W   = pulse_seq_pkg::CNT_W,
   parameter int BURST_W = pulse_seq_pkg::BURST_W
);

   logic               cfg_valid;
   logic               cfg_ready;
   logic [CNT_W-1:0]   cfg_div;
   logic [BURST_W-1:0] cfg_count;
   logic               start;
   logic               stop;
   logic               pulse;
   logic               tick;
   logic               busy;
   logic               done;

   modport master (
      output cfg_valid, cfg_div, cfg_count, start, stop,
      input  cfg_ready, pulse, tick, busy, done
   );

   modport slave (
      input  cfg_valid, cfg_div, cfg_count, start, stop,
      output cfg_ready, pulse, tick, busy, done
   );

endinterface

// File: rtl/div_counter.sv
// Half-period cycle counter with equality compare and registered tick.
// hit is combinational so the parent can act in the same cycle.
module div_counter #(
   parameter int CNT_W = pulse_seq_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] div,
   output logic             hit,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;

   assign hit = en && (cnt == div);

   // clr wins over hit so an abort never leaves a stray tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (hit) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         if (en) cnt <= cnt + CNT_W'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/pulse_sequencer.sv
// Programmable square-wave burst generator with config handshake.
// FSM, config registers, period counter and output registers.
module pulse_sequencer #(
   parameter int CNT_W   = pulse_seq_pkg::CNT_W,
   parameter int BURST_W = pulse_seq_pkg::BURST_W
) (
   input logic              clk,
   input logic              reset_n,
   pulse_sequencer_if.slave bus
);
   import pulse_seq_pkg::*;

   state_t             state;
   state_t             state_n;
   logic [CNT_W-1:0]   div_r;
   logic [BURST_W-1:0] count_r;
   logic [BURST_W-1:0] period;
   logic [BURST_W-1:0] period_n;
   logic [BURST_W-1:0] period_inc;
   logic               pulse_n;
   logic               done_n;
   logic               load;
   logic               clr;
   logic               hit;

   assign bus.cfg_ready = (state != RUN);

   div_counter #(.CNT_W(CNT_W)) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state == RUN),
      .clr     (clr),
      .div     (div_r),
      .hit     (hit),
      .tick    (bus.tick)
   );

   always_comb begin
      state_n    = state;
      pulse_n    = bus.pulse;
      done_n     = 1'b0;
      period_n   = period;
      clr        = 1'b0;
      load       = bus.cfg_valid && (state != RUN);
      period_inc = (period == '1) ? period : period + BURST_W'(1);
      unique case (1'b1)
         (state == IDLE): begin
            if (load) state_n = ARMED;
         end
         (state == ARMED): begin
            if (bus.start && !bus.stop) begin
               state_n  = RUN;
               clr      = 1'b1;
               pulse_n  = 1'b0;
               period_n = '0;
            end
         end
         (state == RUN): begin
            if (bus.stop) begin
               state_n  = ARMED;
               clr      = 1'b1;
               pulse_n  = 1'b0;
               period_n = '0;
            end else if (hit) begin
               pulse_n = !bus.pulse;
               // a falling toggle closes one full period
               if (bus.pulse) begin
                  period_n = period_inc;
                  if (count_r != '0 && period_inc == count_r) begin
                     done_n   = 1'b1;
                     pulse_n  = 1'b0;
                     period_n = '0;
                     state_n  = ARMED;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         div_r     <= '0;
         count_r   <= '0;
         period    <= '0;
         bus.pulse <= 1'b0;
         bus.done  <= 1'b0;
         bus.busy  <= 1'b0;
      end else begin
         state     <= state_n;
         period    <= period_n;
         bus.pulse <= pulse_n;
         bus.done  <= done_n;
         bus.busy  <= (state_n == RUN);
         if (load) begin
            div_r   <= bus.cfg_div;
            count_r <= bus.cfg_count;
         end
      end
   end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench: stimulus queues expected tick/done events,
// a negedge monitor pops and compares whenever tick or done fires.
module tb_pulse_sequencer;
   import pulse_seq_pkg::*;

   typedef struct {
      int   cyc;
      logic pulse;
      logic done;
      logic busy;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   cs;
   ev_t  sb[$];

   pulse_sequencer_if #(.CNT_W(30), .BURST_W(8)) bus ();

   pulse_sequencer #(.CNT_W(30), .BURST_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input logic p, input logic d, input logic b);
      ev_t e;
      e.cyc = c;
      e.pulse = p;
      e.done = d;
      e.busy = b;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (bus.tick || bus.done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: cyc %0d tick=%b done=%b, none expected",
                     cyc, bus.tick, bus.done);
         end else begin
            ev_t e;
            e = sb.pop_front();
            check("ev_cyc", cyc, e.cyc);
            check("ev_tick", int'(bus.tick), 1);
            check("ev_pulse", int'(bus.pulse), int'(e.pulse));
            check("ev_done", int'(bus.done), int'(e.done));
            check("ev_busy", int'(bus.busy), int'(e.busy));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_div = '0;
      bus.cfg_count = '0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      step(2);
      check("rst_pulse", int'(bus.pulse), 0);
      check("rst_tick", int'(bus.tick), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_cfg_ready", int'(bus.cfg_ready), 1);
      reset_n = 1'b1;
      step(1);

      // div=3 count=2: ticks at +4,+8,+12,+16, done at +16
      bus.cfg_valid = 1'b1;
      bus.cfg_div = 30'd3;
      bus.cfg_count = 8'd2;
      step(1);
      bus.cfg_valid = 1'b0;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      cs = cyc;
      push(cs + 4, 1'b1, 1'b0, 1'b1);
      push(cs + 8, 1'b0, 1'b0, 1'b1);
      push(cs + 12, 1'b1, 1'b0, 1'b1);
      push(cs + 16, 1'b0, 1'b1, 1'b0);
      check("s1_busy", int'(bus.busy), 1);
      check("s1_cfg_ready_run", int'(bus.cfg_ready), 0);
      check("s1_pulse_entry", int'(bus.pulse), 0);
      step(20);
      check("s1_busy_end", int'(bus.busy), 0);
      check("s1_cfg_ready_end", int'(bus.cfg_ready), 1);
      check("s1_sb_empty", sb.size(), 0);

      // div=0 count=0: toggle every cycle, stop sampled at +10
      bus.cfg_valid = 1'b1;
      bus.cfg_div = 30'd0;
      bus.cfg_count = 8'd0;
      step(1);
      bus.cfg_valid = 1'b0;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      cs = cyc;
      for (int k = 1; k <= 9; k++) push(cs + k, logic'(k % 2), 1'b0, 1'b1);
      step(9);
      bus.stop = 1'b1;
      step(1);
      bus.stop = 1'b0;
      check("s2_pulse_stop", int'(bus.pulse), 0);
      check("s2_busy_stop", int'(bus.busy), 0);
      check("s2_tick_stop", int'(bus.tick), 0);
      step(3);
      check("s2_sb_empty", sb.size(), 0);

      // start+stop together in ARMED: stays ARMED
      bus.start = 1'b1;
      bus.stop = 1'b1;
      step(1);
      bus.start = 1'b0;
      bus.stop = 1'b0;
      check("s3_busy", int'(bus.busy), 0);
      check("s3_cfg_ready", int'(bus.cfg_ready), 1);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      check("s3_armed_kept", int'(bus.busy), 1);
      bus.stop = 1'b1;
      step(1);
      bus.stop = 1'b0;
      check("s3_stop_busy", int'(bus.busy), 0);
      step(2);

      // start without config after reset is ignored
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(1);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      check("s4_nocfg_busy", int'(bus.busy), 0);
      step(3);
      check("s4_nocfg_pulse", int'(bus.pulse), 0);

      // cfg during RUN refused; reset mid-period with pulse high
      bus.cfg_valid = 1'b1;
      bus.cfg_div = 30'd5;
      bus.cfg_count = 8'd0;
      step(1);
      bus.cfg_valid = 1'b0;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      cs = cyc;
      push(cs + 6, 1'b1, 1'b0, 1'b1);
      push(cs + 12, 1'b0, 1'b0, 1'b1);
      push(cs + 18, 1'b1, 1'b0, 1'b1);
      step(2);
      bus.cfg_valid = 1'b1;
      bus.cfg_div = 30'd1;
      bus.cfg_count = 8'd1;
      #1;
      check("s4_cfg_ready_run", int'(bus.cfg_ready), 0);
      step(2);
      bus.cfg_valid = 1'b0;
      step(16);
      check("s4_pulse_hi", int'(bus.pulse), 1);
      reset_n = 1'b0;
      #1;
      check("s4_rst_pulse", int'(bus.pulse), 0);
      check("s4_rst_busy", int'(bus.busy), 0);
      check("s4_rst_cfg_ready", int'(bus.cfg_ready), 1);
      step(2);
      reset_n = 1'b1;
      step(1);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      check("s4_cfg_required", int'(bus.busy), 0);
      check("s4_sb_empty", sb.size(), 0);

      // config and start in same ARMED cycle use the new values
      bus.cfg_valid = 1'b1;
      bus.cfg_div = 30'd7;
      bus.cfg_count = 8'd3;
      step(1);
      bus.cfg_div = 30'd1;
      bus.cfg_count = 8'd1;
      bus.start = 1'b1;
      step(1);
      bus.cfg_valid = 1'b0;
      bus.start = 1'b0;
      cs = cyc;
      push(cs + 2, 1'b1, 1'b0, 1'b1);
      push(cs + 4, 1'b0, 1'b1, 1'b0);
      step(8);
      check("s5_busy_end", int'(bus.busy), 0);
      check("s5_cfg_ready", int'(bus.cfg_ready), 1);
      check("s5_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 30, the divider counter width in bits.
REQ-002 The block SHALL have parameter BURST_W, default 8, the burst period-count width in bits.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port cfg_valid  input  1  configuration offered.
REQ-006 The block SHALL have port cfg_ready  output  1  configuration can be accepted.
REQ-007 The block SHALL have port cfg_div  input  CNT_W  half-period length in clk cycles, minus 1.
REQ-008 The block SHALL have port cfg_count  input  BURST_W  full pulse periods per burst; 0 means continuous.
REQ-009 The block SHALL have port start  input  1  one-cycle request to begin generation.
REQ-010 The block SHALL have port stop  input  1  one-cycle request to abort generation.
REQ-011 The block SHALL have port pulse  output  1  registered square-wave output.
REQ-012 The block SHALL have port tick  output  1  one-cycle registered strobe coincident with every pulse toggle.
REQ-013 The block SHALL have port busy  output  1  high while state is RUN.
REQ-014 The block SHALL have port done  output  1  one-cycle strobe on burst completion.

Function
REQ-015 The FSM SHALL have states IDLE (no valid config), ARMED (config held), and RUN (generating).
REQ-016 cfg_ready SHALL be 1 in IDLE and ARMED and 0 in RUN.
REQ-017 A config SHALL be accepted on a cycle where cfg_valid and cfg_ready are both 1: cfg_div and cfg_count are latched into div_r and count_r, and the state goes to ARMED.
REQ-018 start in ARMED with stop low SHALL enter RUN next cycle, clearing the cycle counter and period counter, with pulse=0.
REQ-019 start in IDLE or RUN SHALL be ignored.
REQ-020 If config acceptance and start occur in the same ARMED cycle, RUN SHALL use the newly accepted values.
REQ-021 In RUN the cycle counter SHALL increment by 1 per clk.
REQ-022 When the cycle counter equals div_r, the block SHALL, in one cycle: reset the counter to 0, toggle pulse, and assert tick for one cycle.
REQ-023 Toggle spacing SHALL be div_r+1 cycles; div_r=0 SHALL toggle every cycle.
REQ-024 The first toggle SHALL occur div_r+1 cycles after RUN entry.
REQ-025 The period counter SHALL increment on each 1->0 toggle of pulse.
REQ-026 Counter arithmetic SHALL be unsigned, with no wrap-around reachable: compare on equality, reset to 0.
REQ-027 When count_r!=0 and the period counter reaches count_r: done=1 for that cycle, pulse=0, and the state goes to ARMED with config retained.
REQ-028 When count_r=0, generation SHALL continue until stop; the period counter saturates at its maximum value.
REQ-029 stop in RUN SHALL take effect next cycle: go to ARMED, pulse=0, tick=0, counters cleared, no done.
REQ-030 stop outside RUN SHALL be ignored.
REQ-031 If start and stop are both asserted in the same cycle, stop SHALL win; in ARMED the state stays ARMED.

Reset
REQ-032 reset_n low SHALL immediately force: state IDLE, pulse=0, tick=0, done=0, busy=0, counters=0, div_r=0, count_r=0.
REQ-033 cfg_ready SHALL be 1 during reset and SHALL be registered low only when RUN is entered.
REQ-034 Reset asserted mid-RUN SHALL abort generation with no done.
REQ-035 After reset, a new config SHALL be required before start is honoured.

Structure
REQ-036 Package pulse_seq_pkg SHALL hold the FSM state enum (IDLE, ARMED, RUN) and default width constants CNT_W=30 and BURST_W=8.
REQ-037 Sub-module div_counter SHALL implement the CNT_W cycle counter, the equality compare against div_r, and tick generation, with enable and clear inputs.
REQ-038 pulse_sequencer SHALL hold the FSM, config registers, period counter, and output registers.
REQ-039 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs except cfg_ready, which is decoded from state only.

Verification
REQ-040 Scenario: config div=3, count=2, then start -> ticks at cycles 4, 8, 12, 16 after RUN entry; pulse high for 4 cycles, twice; done at cycle 16; state ARMED.
REQ-041 Scenario: div=0, count=0, start, then stop after 10 cycles -> pulse toggles every cycle; after stop, pulse=0, busy=0, no done.
REQ-042 Scenario: start and stop asserted together in ARMED -> state stays ARMED, busy stays 0.
REQ-043 Scenario: start with no prior config after reset -> no RUN, pulse stays 0; cfg_valid asserted during RUN -> cfg_ready=0 and div_r unchanged.
REQ-044 Scenario: reset_n pulled low mid-period while pulse=1 -> pulse=0 asynchronously, state IDLE, done never asserted.
REQ-045 Scenario: config accepted in the same cycle as start (div=1, count=1) -> new values used; ticks at cycles 2 and 4, done at cycle 4.
